pick_ms_nch: RTL and testbench



---
 rtl/pick_ms_nch.sv | 215 +++++++++++++++++++++
 tb/tb_pick_ms_nch.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pick_ms_nch.sv
// pick_ms_nch: multi-channel PICK actor with per-channel input FIFOs.
// MODE=0 drains channels in strict cyclic order; MODE=1 follows a select-token stream.
module pick_ms_nch #(
   parameter int unsigned FLUX       = 2,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TAG_WIDTH  = $clog2(FLUX),
   parameter int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned SEL_DEPTH  = 2,
   parameter int unsigned MODE       = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_port_write,
   input  logic [WIDTH-1:0]     in_port_datain,
   output logic [FLUX-1:0]      in_port_full,
   input  logic                 in_port_write_nda,
   input  logic [TAG_WIDTH-1:0] in_port_datain_nda,
   output logic                 in_port_full_nda,
   output logic                 out_port_write,
   output logic [WIDTH-1:0]     out_port_dataout,
   input  logic                 out_port_full,
   output logic [1:0]           err_sticky
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned SPW = $clog2(SEL_DEPTH);
   localparam int unsigned SCW = SPW + 1;

   typedef enum logic {SEL_WAIT, DATA_WAIT} ddf_state_e;

   // channel FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] mem_q    [FLUX][DEPTH];
   logic [PW-1:0]         wr_ptr_q [FLUX];
   logic [PW-1:0]         rd_ptr_q [FLUX];
   logic [CW-1:0]         cnt_q    [FLUX];
   logic [CW-1:0]         cnt_d    [FLUX];
   logic [FLUX-1:0]       push;
   logic [FLUX-1:0]       pop;

   // select FIFO storage and bookkeeping
   logic [TAG_WIDTH-1:0]  sel_mem_q [SEL_DEPTH];
   logic [SPW-1:0]        sel_wr_q;
   logic [SPW-1:0]        sel_rd_q;
   logic [SCW-1:0]        sel_cnt_q;
   logic [SCW-1:0]        sel_cnt_d;
   logic                  sel_push;
   logic                  sel_pop;
   logic                  sel_drop;

   logic [TAG_WIDTH-1:0]  in_tag;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  wr_drop;

   logic [TAG_WIDTH-1:0]  sdf_ptr_q;
   logic [TAG_WIDTH-1:0]  sdf_ptr_d;
   ddf_state_e            state_q;
   ddf_state_e            state_d;

   logic                  pick_en;
   logic [TAG_WIDTH-1:0]  pick_ch;
   logic                  pick_ok;
   logic                  pick_nz;
   logic [DATA_WIDTH-1:0] pick_data;
   logic                  sel_inv;
   logic                  emit;
   logic [WIDTH-1:0]      out_data_d;
   logic [1:0]            err_d;

   // per-channel full flags straight from the occupancy counters
   always_comb begin
      for (int unsigned i = 0; i < FLUX; i++) begin
         in_port_full[i] = (cnt_q[i] == CW'(DEPTH));
      end
   end

   // steer an incoming token to its channel; a full target or an unknown tag drops it
   always_comb begin
      in_tag  = in_port_datain[WIDTH-1:DATA_WIDTH];
      in_data = in_port_datain[DATA_WIDTH-1:0];
      push    = '0;
      for (int unsigned i = 0; i < FLUX; i++) begin
         if (in_port_write && (in_tag == TAG_WIDTH'(i)) && !in_port_full[i]) begin
            push[i] = 1'b1;
         end
      end
      wr_drop = in_port_write && (push == '0);
   end

   // select FIFO write side, only alive in select-driven mode
   always_comb begin
      in_port_full_nda = 1'b0;
      sel_push         = 1'b0;
      sel_drop         = 1'b0;
      if (MODE == 1) begin
         in_port_full_nda = (sel_cnt_q == SCW'(SEL_DEPTH));
         sel_push         = in_port_write_nda && !in_port_full_nda;
         sel_drop         = in_port_write_nda && in_port_full_nda;
      end
   end

   // pick channel, emit decision, pointer/FSM next state and output next values
   always_comb begin
      state_d   = state_q;
      sdf_ptr_d = sdf_ptr_q;
      pick_en   = 1'b0;
      pick_ch   = '0;
      pick_nz   = 1'b0;
      pick_data = '0;
      sel_pop   = 1'b0;
      sel_inv   = 1'b0;
      emit      = 1'b0;
      pop       = '0;

      if (MODE == 0) begin
         pick_en = 1'b1;
         pick_ch = sdf_ptr_q;
      end else if (state_q == DATA_WAIT) begin
         pick_en = 1'b1;
         pick_ch = sel_mem_q[sel_rd_q];
      end

      pick_ok = (32'(pick_ch) < 32'(FLUX));
      for (int unsigned i = 0; i < FLUX; i++) begin
         if (pick_ch == TAG_WIDTH'(i)) begin
            pick_nz   = (cnt_q[i] != '0);
            pick_data = mem_q[i][rd_ptr_q[i]];
         end
      end

      if (pick_en) begin
         if (!pick_ok) begin
            // bad select values are discarded without emitting
            sel_pop = 1'b1;
            sel_inv = 1'b1;
         end else if (!out_port_full && pick_nz) begin
            emit = 1'b1;
            if (MODE == 0) begin
               sdf_ptr_d = (sdf_ptr_q == TAG_WIDTH'(FLUX - 1)) ? '0 : sdf_ptr_q + TAG_WIDTH'(1);
            end else begin
               sel_pop = 1'b1;
            end
         end
      end

      for (int unsigned i = 0; i < FLUX; i++) begin
         pop[i]   = emit && (pick_ch == TAG_WIDTH'(i));
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      sel_cnt_d = sel_cnt_q + SCW'(sel_push) - SCW'(sel_pop);

      case (state_q)
         SEL_WAIT:  if (sel_cnt_q != '0) state_d = DATA_WAIT;
         DATA_WAIT: if (sel_cnt_d == '0) state_d = SEL_WAIT;
         default:   state_d = SEL_WAIT;
      endcase

      out_data_d = emit ? {pick_ch, pick_data} : out_port_dataout;
      err_d      = err_sticky | {sel_inv, wr_drop | sel_drop};
   end

   // channel FIFO pointers and counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < FLUX; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < FLUX; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // channel FIFO payload storage
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < FLUX; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data;
      end
   end

   // select FIFO payload storage
   always_ff @(posedge clk) begin
      if (sel_push) sel_mem_q[sel_wr_q] <= in_port_datain_nda;
   end

   // select FIFO pointers, cyclic pointer, FSM state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_wr_q         <= '0;
         sel_rd_q         <= '0;
         sel_cnt_q        <= '0;
         sdf_ptr_q        <= '0;
         state_q          <= SEL_WAIT;
         out_port_write   <= 1'b0;
         out_port_dataout <= '0;
         err_sticky       <= '0;
      end else begin
         if (sel_push) sel_wr_q <= sel_wr_q + SPW'(1);
         if (sel_pop)  sel_rd_q <= sel_rd_q + SPW'(1);
         sel_cnt_q        <= sel_cnt_d;
         sdf_ptr_q        <= sdf_ptr_d;
         state_q          <= state_d;
         out_port_write   <= emit;
         out_port_dataout <= out_data_d;
         err_sticky       <= err_d;
      end
   end

endmodule

// File: tb/tb_pick_ms_nch.sv
// Bench for pick_ms_nch: cyclic instance (FLUX=2) and two select-driven instances (FLUX=4, FLUX=3).
module tb_pick_ms_nch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // u0: MODE=0, FLUX=2
   logic       u0_wr, u0_wr_nda, u0_full_nda, u0_ow, u0_of;
   logic [8:0] u0_din, u0_dout;
   logic [1:0] u0_full, u0_err;
   logic [0:0] u0_din_nda;
   // u1: MODE=1, FLUX=4
   logic       u1_wr, u1_wr_nda, u1_full_nda, u1_ow, u1_of;
   logic [9:0] u1_din, u1_dout;
   logic [3:0] u1_full;
   logic [1:0] u1_err, u1_din_nda;
   // u2: MODE=1, FLUX=3
   logic       u2_wr, u2_wr_nda, u2_full_nda, u2_ow, u2_of;
   logic [9:0] u2_din, u2_dout;
   logic [2:0] u2_full;
   logic [1:0] u2_err, u2_din_nda;

   pick_ms_nch #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(4), .SEL_DEPTH(2), .MODE(0)) u0 (
      .clk(clk), .rst(rst),
      .in_port_write(u0_wr), .in_port_datain(u0_din), .in_port_full(u0_full),
      .in_port_write_nda(u0_wr_nda), .in_port_datain_nda(u0_din_nda), .in_port_full_nda(u0_full_nda),
      .out_port_write(u0_ow), .out_port_dataout(u0_dout), .out_port_full(u0_of),
      .err_sticky(u0_err));

   pick_ms_nch #(.FLUX(4), .DATA_WIDTH(8), .DEPTH(4), .SEL_DEPTH(2), .MODE(1)) u1 (
      .clk(clk), .rst(rst),
      .in_port_write(u1_wr), .in_port_datain(u1_din), .in_port_full(u1_full),
      .in_port_write_nda(u1_wr_nda), .in_port_datain_nda(u1_din_nda), .in_port_full_nda(u1_full_nda),
      .out_port_write(u1_ow), .out_port_dataout(u1_dout), .out_port_full(u1_of),
      .err_sticky(u1_err));

   pick_ms_nch #(.FLUX(3), .DATA_WIDTH(8), .DEPTH(4), .SEL_DEPTH(2), .MODE(1)) u2 (
      .clk(clk), .rst(rst),
      .in_port_write(u2_wr), .in_port_datain(u2_din), .in_port_full(u2_full),
      .in_port_write_nda(u2_wr_nda), .in_port_datain_nda(u2_din_nda), .in_port_full_nda(u2_full_nda),
      .out_port_write(u2_ow), .out_port_dataout(u2_dout), .out_port_full(u2_of),
      .err_sticky(u2_err));

   // observed output tokens, one entry per strobe cycle
   logic [8:0] obs0[$];
   logic [9:0] obs1[$];
   logic [9:0] obs2[$];
   // expected tokens for the select-driven instances
   logic [9:0] exp1[$];
   logic [9:0] exp2[$];
   // cyclic-order model for u0: per-channel payload queues plus pick pointer
   logic [7:0] m0q0[$];
   logic [7:0] m0q1[$];
   bit         m0ptr = 1'b0;

   always @(negedge clk) begin
      if (u0_ow === 1'b1) obs0.push_back(u0_dout);
      if (u1_ow === 1'b1) obs1.push_back(u1_dout);
      if (u2_ow === 1'b1) obs2.push_back(u2_dout);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // next token the cyclic model says u0 must emit
   function automatic void m0_next(output bit ok, output logic [8:0] e);
      ok = 1'b0;
      e  = '0;
      if (!m0ptr && m0q0.size() > 0) begin
         e = {1'b0, m0q0.pop_front()}; ok = 1'b1; m0ptr = 1'b1;
      end else if (m0ptr && m0q1.size() > 0) begin
         e = {1'b1, m0q1.pop_front()}; ok = 1'b1; m0ptr = 1'b0;
      end
   endfunction

   task automatic u0_write(input logic t, input logic [7:0] d, input bit keep);
      u0_wr  = 1'b1;
      u0_din = {t, d};
      if (keep) begin
         if (t) m0q1.push_back(d); else m0q0.push_back(d);
      end
      @(posedge clk); #1;
      u0_wr = 1'b0;
   endtask

   task automatic u1_data(input logic [1:0] t, input logic [7:0] d);
      u1_wr = 1'b1; u1_din = {t, d};
      @(posedge clk); #1;
      u1_wr = 1'b0;
   endtask

   task automatic u1_sel(input logic [1:0] s, input logic [7:0] d);
      int budget;
      budget = 20;
      while (u1_full_nda && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL u1_sel_wait: in_port_full_nda=%0b never cleared, required 0", u1_full_nda);
      end
      u1_wr_nda = 1'b1; u1_din_nda = s;
      exp1.push_back({s, d});
      @(posedge clk); #1;
      u1_wr_nda = 1'b0;
   endtask

   task automatic u2_data(input logic [1:0] t, input logic [7:0] d);
      u2_wr = 1'b1; u2_din = {t, d};
      @(posedge clk); #1;
      u2_wr = 1'b0;
   endtask

   task automatic u2_sel(input logic [1:0] s);
      u2_wr_nda = 1'b1; u2_din_nda = s;
      @(posedge clk); #1;
      u2_wr_nda = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({u0_ow, u0_dout, u0_err, u0_full, u0_full_nda} !== '0) begin
         errors++;
         $display("FAIL reset_u0: ow=%b dout=%h err=%b full=%b full_nda=%b required all 0",
                  u0_ow, u0_dout, u0_err, u0_full, u0_full_nda);
      end
      checks++;
      if ({u1_ow, u1_dout, u1_err, u1_full, u1_full_nda} !== '0) begin
         errors++;
         $display("FAIL reset_u1: ow=%b dout=%h err=%b full=%b full_nda=%b required all 0",
                  u1_ow, u1_dout, u1_err, u1_full, u1_full_nda);
      end
      checks++;
      if ({u2_ow, u2_dout, u2_err, u2_full, u2_full_nda} !== '0) begin
         errors++;
         $display("FAIL reset_u2: ow=%b dout=%h err=%b full=%b full_nda=%b required all 0",
                  u2_ow, u2_dout, u2_err, u2_full, u2_full_nda);
      end
      @(negedge clk);
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_sdf_order();
      logic [8:0] got, e;
      bit ok;
      int n;
      u0_write(1'b0, 8'h11, 1'b1);
      u0_write(1'b0, 8'h12, 1'b1);
      u0_write(1'b1, 8'h21, 1'b1);
      tick(6);
      // ch1 is empty now so the block must be stalled after three tokens
      n = obs0.size();
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL sdf_stall_count: emitted=%0d required 3", n);
      end
      u0_write(1'b1, 8'h22, 1'b1);
      tick(4);
      n = obs0.size();
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL sdf_total_count: emitted=%0d required 4", n);
      end
      while (obs0.size() > 0) begin
         got = obs0.pop_front();
         m0_next(ok, e);
         checks++;
         if (!ok || got !== e) begin
            errors++;
            $display("FAIL sdf_order: out=%h required=%h model_has_token=%0d", got, e, ok);
         end
      end
   endtask

   task automatic test_latency();
      logic [8:0] got, e;
      bit ok;
      u0_wr = 1'b1; u0_din = {1'b0, 8'h77};
      m0q0.push_back(8'h77);
      @(posedge clk); #1;
      u0_wr = 1'b0;
      @(negedge clk);
      checks++;
      if (u0_ow !== 1'b0) begin
         errors++;
         $display("FAIL latency_t0: out_port_write=%b required 0", u0_ow);
      end
      @(negedge clk);
      checks++;
      if (u0_ow !== 1'b1 || u0_dout !== 9'h077) begin
         errors++;
         $display("FAIL latency_t1: out_port_write=%b dout=%h required 1/077", u0_ow, u0_dout);
      end
      @(negedge clk);
      checks++;
      if (u0_ow !== 1'b0) begin
         errors++;
         $display("FAIL latency_t2: out_port_write=%b required 0", u0_ow);
      end
      tick(1);
      while (obs0.size() > 0) begin
         got = obs0.pop_front();
         m0_next(ok, e);
         checks++;
         if (!ok || got !== e) begin
            errors++;
            $display("FAIL latency_token: out=%h required=%h model_has_token=%0d", got, e, ok);
         end
      end
   endtask

   task automatic test_full();
      logic [8:0] got, e;
      bit ok;
      int n;
      u0_of = 1'b1;
      for (int i = 0; i < 4; i++) u0_write(1'b1, 8'(8'h40 + i), 1'b1);
      checks++;
      if (u0_full !== 2'b10 || u0_err !== 2'b00) begin
         errors++;
         $display("FAIL full_after4: full=%b err=%b required 10/00", u0_full, u0_err);
      end
      u0_write(1'b1, 8'h44, 1'b0);
      checks++;
      if (u0_full !== 2'b10 || u0_err !== 2'b01) begin
         errors++;
         $display("FAIL full_drop: full=%b err=%b required 10/01", u0_full, u0_err);
      end
      tick(3);
      checks++;
      if (obs0.size() != 0) begin
         errors++;
         $display("FAIL full_hold: emitted=%0d required 0 while out_port_full", obs0.size());
      end
      u0_of = 1'b0;
      for (int i = 0; i < 4; i++) u0_write(1'b0, 8'(8'h50 + i), 1'b1);
      tick(8);
      n = obs0.size();
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL full_release_count: emitted=%0d required 8", n);
      end
      while (obs0.size() > 0) begin
         got = obs0.pop_front();
         m0_next(ok, e);
         checks++;
         if (!ok || got !== e) begin
            errors++;
            $display("FAIL full_release_order: out=%h required=%h model_has_token=%0d", got, e, ok);
         end
      end
      checks++;
      if (m0q0.size() + m0q1.size() != 0) begin
         errors++;
         $display("FAIL full_leftover: model tokens left=%0d required 0", m0q0.size() + m0q1.size());
      end
   endtask

   task automatic test_ddf();
      logic [9:0] got, e;
      int n;
      u1_data(2'd3, 8'hA0);
      u1_data(2'd3, 8'hA1);
      u1_data(2'd0, 8'hB0);
      tick(6);
      checks++;
      if (obs1.size() != 0) begin
         errors++;
         $display("FAIL ddf_no_select: emitted=%0d required 0", obs1.size());
      end
      u1_sel(2'd3, 8'hA0);
      u1_sel(2'd0, 8'hB0);
      checks++;
      if (u1_full_nda !== 1'b1) begin
         errors++;
         $display("FAIL ddf_sel_full: in_port_full_nda=%b required 1", u1_full_nda);
      end
      u1_sel(2'd3, 8'hA1);
      tick(8);
      n = obs1.size();
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL ddf_count: emitted=%0d required 3", n);
      end
      while (obs1.size() > 0 && exp1.size() > 0) begin
         got = obs1.pop_front();
         e   = exp1.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL ddf_order: out=%h required=%h", got, e);
         end
      end
      checks++;
      if (u1_err !== 2'b00 || u1_full !== 4'b0000) begin
         errors++;
         $display("FAIL ddf_status: err=%b full=%b required 00/0000", u1_err, u1_full);
      end
   endtask

   task automatic test_ddf_invalid();
      logic [9:0] got, e;
      u2_data(2'd1, 8'h5C);
      u2_sel(2'd3);
      u2_sel(2'd1);
      exp2.push_back({2'd1, 8'h5C});
      tick(6);
      checks++;
      if (u2_err !== 2'b10) begin
         errors++;
         $display("FAIL ddf_invalid_err: err=%b required 10", u2_err);
      end
      checks++;
      if (obs2.size() != 1) begin
         errors++;
         $display("FAIL ddf_invalid_count: emitted=%0d required 1", obs2.size());
      end
      while (obs2.size() > 0 && exp2.size() > 0) begin
         got = obs2.pop_front();
         e   = exp2.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL ddf_invalid_token: out=%h required=%h", got, e);
         end
      end
      // tag 3 does not exist when FLUX=3
      u2_data(2'd3, 8'hEE);
      tick(2);
      checks++;
      if (u2_err !== 2'b11 || u2_full !== 3'b000) begin
         errors++;
         $display("FAIL ddf_bad_tag: err=%b full=%b required 11/000", u2_err, u2_full);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] got, e;
      bit ok;
      int n;
      for (int i = 0; i < 8; i++) begin
         u0_of = (i % 2 == 1);
         u0_write(1'(i), 8'(8'h60 + i), 1'b1);
      end
      u0_of = 1'b0;
      tick(12);
      n = obs0.size();
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL bp_count: emitted=%0d required 8", n);
      end
      while (obs0.size() > 0) begin
         got = obs0.pop_front();
         m0_next(ok, e);
         checks++;
         if (!ok || got !== e) begin
            errors++;
            $display("FAIL bp_order: out=%h required=%h model_has_token=%0d", got, e, ok);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] got, e;
      bit ok;
      u0_of = 1'b1;
      for (int i = 0; i < 4; i++) u0_write(1'b1, 8'(8'h80 + i), 1'b0);
      checks++;
      if (u0_full !== 2'b10) begin
         errors++;
         $display("FAIL rst_mid_prefill: full=%b required 10", u0_full);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({u0_ow, u0_dout, u0_err, u0_full} !== '0) begin
         errors++;
         $display("FAIL rst_mid_async: ow=%b dout=%h err=%b full=%b required all 0",
                  u0_ow, u0_dout, u0_err, u0_full);
      end
      m0q0.delete(); m0q1.delete(); m0ptr = 1'b0;
      obs0.delete();
      u0_of = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick(5);
      checks++;
      if (obs0.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_empty: emitted=%0d stale tokens required 0", obs0.size());
      end
      u0_write(1'b0, 8'h7A, 1'b1);
      tick(4);
      checks++;
      if (obs0.size() != 1) begin
         errors++;
         $display("FAIL rst_mid_after_count: emitted=%0d required 1", obs0.size());
      end
      while (obs0.size() > 0) begin
         got = obs0.pop_front();
         m0_next(ok, e);
         checks++;
         if (!ok || got !== e) begin
            errors++;
            $display("FAIL rst_mid_after_token: out=%h required=%h model_has_token=%0d", got, e, ok);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      u0_wr = 1'b0; u0_din = '0; u0_wr_nda = 1'b0; u0_din_nda = '0; u0_of = 1'b0;
      u1_wr = 1'b0; u1_din = '0; u1_wr_nda = 1'b0; u1_din_nda = '0; u1_of = 1'b0;
      u2_wr = 1'b0; u2_din = '0; u2_wr_nda = 1'b0; u2_din_nda = '0; u2_of = 1'b0;
      test_reset();
      test_sdf_order();
      test_latency();
      test_full();
      test_ddf();
      test_ddf_invalid();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
